// File: rtl/wb_host_bridge_pkg.sv
// Shared types and constants for the Wishbone host bridge.
package wb_host_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  // Read data returned with an aborted (timed-out) cycle.
  localparam logic [WB_DAT_W-1:0] ERR_DAT = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/wb_host_bridge_if.sv
// Command/response port plus Wishbone initiator signals of the host bridge.
// The master modport is the bridge; the slave modport is its environment
// (command source, response sink and Wishbone responder).
interface wb_host_if;
  import wb_host_pkg::*;

  logic                cmd_valid_i;
  logic                cmd_ready_o;
  logic                cmd_we_i;
  logic [WB_SEL_W-1:0] cmd_sel_i;
  logic [WB_ADR_W-1:0] cmd_adr_i;
  logic [WB_DAT_W-1:0] cmd_dat_i;

  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic [WB_DAT_W-1:0] rsp_dat_o;
  logic                rsp_err_o;

  logic                wbm_cyc_o;
  logic                wbm_stb_o;
  logic                wbm_we_o;
  logic [WB_SEL_W-1:0] wbm_sel_o;
  logic [WB_ADR_W-1:0] wbm_adr_o;
  logic [WB_DAT_W-1:0] wbm_dat_o;
  logic                wbm_ack_i;
  logic [WB_DAT_W-1:0] wbm_dat_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  rsp_ready_i,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_err_o,
    output rsp_ready_i,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i
  );

endinterface

// File: rtl/wb_host_bridge_watchdog.sv
// 16-bit bus watchdog: cleared at cycle start, counts while enabled and
// flags the last permitted cycle (count == TIMEOUT-1). The owner stops
// enabling it once expired, so it never wraps.
module wb_host_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [15:0] LP_LAST = 16'(TIMEOUT - 1);

  logic [15:0] r_cnt;

  // Cycle counter; clear has priority over count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    if (i_rst)      r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 16'd1;
  end

  assign o_expired = (r_cnt == LP_LAST);

endmodule

// File: rtl/wb_host_bridge.sv
// Wishbone classic initiator: one valid/ready command becomes one bus cycle,
// answered by one response. A watchdog aborts cycles that are never ACKed.
module wb_host_bridge
  import wb_host_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int ERR_W   = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  wb_host_if.master        bus,
  output logic [ERR_W-1:0] err_cnt_o
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_cmd_ready;
  logic                r_cyc;
  logic                r_rsp_valid;
  logic                r_we;
  logic [WB_SEL_W-1:0] r_sel;
  logic [WB_ADR_W-1:0] r_adr;
  logic [WB_DAT_W-1:0] r_dat;
  logic [WB_DAT_W-1:0] r_rsp_dat;
  logic                r_rsp_err;
  logic [ERR_W-1:0]    r_err_cnt;

  logic w_cmd_hs;
  logic w_ack_done;
  logic w_abort;
  logic w_wd_clr;
  logic w_wd_en;
  logic w_expired;

  wb_host_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .i_clk     (wb_clk_i),
    .i_rst     (wb_rst_i),
    .i_clr     (w_wd_clr),
    .i_en      (w_wd_en),
    .o_expired (w_expired)
  );

  // Next-state and per-cycle control decode; ACK beats the watchdog.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    w_state_nxt = r_state;
    w_cmd_hs    = 1'b0;
    w_ack_done  = 1'b0;
    w_abort     = 1'b0;
    w_wd_clr    = 1'b0;
    w_wd_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          w_cmd_hs    = 1'b1;
          w_wd_clr    = 1'b1;
          w_state_nxt = BUS;
        end
      end
      BUS: begin
        if (bus.wbm_ack_i) begin
          w_ack_done  = 1'b1;
          w_state_nxt = RESP;
        end else if (w_expired) begin
          w_abort     = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_wd_en = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register plus registered state-decoded handshake/bus qualifiers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b1;
      r_cyc       <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == IDLE);
      r_cyc       <= (w_state_nxt == BUS);
      r_rsp_valid <= (w_state_nxt == RESP);
    end
  end

  // Command capture, response capture and saturating timeout counter.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_rsp_dat <= '0;
      r_rsp_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_cmd_hs) begin
        r_we  <= bus.cmd_we_i;
        r_sel <= bus.cmd_sel_i;
        r_adr <= bus.cmd_adr_i;
        r_dat <= bus.cmd_dat_i;
      end
      if (w_ack_done) begin
        r_rsp_dat <= r_we ? '0 : bus.wbm_dat_i;
        r_rsp_err <= 1'b0;
      end else if (w_abort) begin
        r_rsp_dat <= ERR_DAT;
        r_rsp_err <= 1'b1;
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
    end
  end

  assign bus.cmd_ready_o = r_cmd_ready;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_dat_o   = r_rsp_dat;
  assign bus.rsp_err_o   = r_rsp_err;
  assign bus.wbm_cyc_o   = r_cyc;
  assign bus.wbm_stb_o   = r_cyc;
  assign bus.wbm_we_o    = r_we;
  assign bus.wbm_sel_o   = r_sel;
  assign bus.wbm_adr_o   = r_adr;
  assign bus.wbm_dat_o   = r_dat;
  assign err_cnt_o       = r_err_cnt;

endmodule

// File: tb/tb_wb_host_bridge.sv
// Directed bench for wb_host_bridge (TIMEOUT=8, ERR_W=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_wb_host_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] err_cnt;
  int         total = 0;
  int         bad   = 0;

  wb_host_if bus_if ();

  wb_host_bridge #(.TIMEOUT(8), .ERR_W(2)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .bus       (bus_if.master),
    .err_cnt_o (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one command and play the responder: ACK on STB cycle ack_at
  // (0 = never). Returns STB cycle count, edges from handshake to response
  // (handshake edge counted as 1), and the response fields. rsp_ready is
  // left low, so the response stays pending on return.
  task automatic do_cmd(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] dat, input int ack_at, input logic [31:0] rdat,
                        output int stb_n, output int lat,
                        output logic [31:0] rsp_dat, output logic rsp_err);
    bit got = 0;
    stb_n = 0;
    lat   = 1;
    chk("pre_cmd_ready", 32'(bus_if.cmd_ready_o), 32'd1);
    bus_if.cmd_valid_i = 1'b1;
    bus_if.cmd_we_i    = we;
    bus_if.cmd_sel_i   = sel;
    bus_if.cmd_adr_i   = adr;
    bus_if.cmd_dat_i   = dat;
    @(posedge clk); #1;
    bus_if.cmd_valid_i = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (bus_if.rsp_valid_o) begin
        got = 1;
        break;
      end
      if (bus_if.wbm_stb_o) begin
        stb_n++;
        if (stb_n == 1) begin
          chk("bus_cyc", 32'(bus_if.wbm_cyc_o), 32'd1);
          chk("bus_we",  32'(bus_if.wbm_we_o), 32'(we));
          chk("bus_sel", 32'(bus_if.wbm_sel_o), 32'(sel));
          chk("bus_adr", bus_if.wbm_adr_o, adr);
          if (we) chk("bus_dat", bus_if.wbm_dat_o, dat);
        end
        bus_if.wbm_ack_i = (stb_n == ack_at);
        bus_if.wbm_dat_i = (stb_n == ack_at) ? rdat : 32'hDEAD_BEEF;
      end
      @(posedge clk); #1;
      lat++;
      bus_if.wbm_ack_i = 1'b0;
      bus_if.wbm_dat_i = 32'hDEAD_BEEF;
    end
    if (!got) chk("rsp_wait_budget", 32'd0, 32'd1);
    chk("rsp_cyc_low", 32'(bus_if.wbm_cyc_o), 32'd0);
    rsp_dat = bus_if.rsp_dat_o;
    rsp_err = bus_if.rsp_err_o;
  endtask

  // Consume the pending response; the bridge must be ready one cycle later.
  task automatic consume();
    bus_if.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus_if.rsp_ready_i = 1'b0;
    chk("post_rsp_valid", 32'(bus_if.rsp_valid_o), 32'd0);
    chk("post_cmd_ready", 32'(bus_if.cmd_ready_o), 32'd1);
  endtask

  int          stb_n, lat;
  logic [31:0] rdat;
  logic        rerr;

  initial begin
    rst                = 1'b1;
    bus_if.cmd_valid_i = 1'b0;
    bus_if.cmd_we_i    = 1'b0;
    bus_if.cmd_sel_i   = 4'h0;
    bus_if.cmd_adr_i   = 32'h0;
    bus_if.cmd_dat_i   = 32'h0;
    bus_if.rsp_ready_i = 1'b0;
    bus_if.wbm_ack_i   = 1'b0;
    bus_if.wbm_dat_i   = 32'hDEAD_BEEF;

    // Reset values
    #3;
    chk("rst_cmd_ready", 32'(bus_if.cmd_ready_o), 32'd1);
    chk("rst_cyc",       32'(bus_if.wbm_cyc_o), 32'd0);
    chk("rst_stb",       32'(bus_if.wbm_stb_o), 32'd0);
    chk("rst_rsp_valid", 32'(bus_if.rsp_valid_o), 32'd0);
    chk("rst_err_cnt",   32'(err_cnt), 32'd0);
    chk("rst_adr",       bus_if.wbm_adr_o, 32'd0);
    #9 rst = 1'b0;
    @(posedge clk); #1;

    // Zero-wait write
    do_cmd(1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_5A5A, 1, 32'h1111_2222, stb_n, lat, rdat, rerr);
    chk("wr_stb_n", 32'(stb_n), 32'd1);
    chk("wr_lat",   32'(lat), 32'd2);
    chk("wr_dat",   rdat, 32'h0);
    chk("wr_err",   32'(rerr), 32'd0);
    consume();
    chk("wr_adr_hold", bus_if.wbm_adr_o, 32'h3000_0004);

    // Read with 3 wait states
    do_cmd(1'b0, 4'h3, 32'h3000_0010, 32'h0, 4, 32'h1234_5678, stb_n, lat, rdat, rerr);
    chk("rd_stb_n", 32'(stb_n), 32'd4);
    chk("rd_lat",   32'(lat), 32'd5);
    chk("rd_dat",   rdat, 32'h1234_5678);
    chk("rd_err",   32'(rerr), 32'd0);
    consume();

    // Timeout, then a late ACK during the response
    do_cmd(1'b0, 4'hF, 32'h3000_0020, 32'h0, 0, 32'h0, stb_n, lat, rdat, rerr);
    chk("to_stb_n",   32'(stb_n), 32'd8);
    chk("to_lat",     32'(lat), 32'd9);
    chk("to_dat",     rdat, 32'h0);
    chk("to_err",     32'(rerr), 32'd1);
    chk("to_err_cnt", 32'(err_cnt), 32'd1);
    bus_if.wbm_ack_i = 1'b1;
    bus_if.wbm_dat_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("late_rsp_valid", 32'(bus_if.rsp_valid_o), 32'd1);
      chk("late_rsp_dat",   bus_if.rsp_dat_o, 32'h0);
      chk("late_rsp_err",   32'(bus_if.rsp_err_o), 32'd1);
      chk("late_cyc",       32'(bus_if.wbm_cyc_o), 32'd0);
      chk("late_err_cnt",   32'(err_cnt), 32'd1);
    end
    bus_if.wbm_ack_i = 1'b0;
    consume();
    chk("late_idle_cyc", 32'(bus_if.wbm_cyc_o), 32'd0);

    // ACK on the exact expiry cycle: ACK wins
    do_cmd(1'b0, 4'hF, 32'h3000_0030, 32'h0, 8, 32'h0BAD_F00D, stb_n, lat, rdat, rerr);
    chk("exp_stb_n",   32'(stb_n), 32'd8);
    chk("exp_dat",     rdat, 32'h0BAD_F00D);
    chk("exp_err",     32'(rerr), 32'd0);
    chk("exp_err_cnt", 32'(err_cnt), 32'd1);
    consume();

    // Backpressure: response held, new command refused until released
    do_cmd(1'b0, 4'hF, 32'h3000_0040, 32'h0, 1, 32'hCAFE_0001, stb_n, lat, rdat, rerr);
    chk("bp_dat", rdat, 32'hCAFE_0001);
    bus_if.cmd_valid_i = 1'b1;
    bus_if.cmd_we_i    = 1'b0;
    bus_if.cmd_sel_i   = 4'h1;
    bus_if.cmd_adr_i   = 32'h4000_0000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", 32'(bus_if.rsp_valid_o), 32'd1);
      chk("bp_rsp_dat",   bus_if.rsp_dat_o, 32'hCAFE_0001);
      chk("bp_cmd_ready", 32'(bus_if.cmd_ready_o), 32'd0);
      chk("bp_cyc",       32'(bus_if.wbm_cyc_o), 32'd0);
    end
    bus_if.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus_if.rsp_ready_i = 1'b0;
    chk("bp_rel_ready", 32'(bus_if.cmd_ready_o), 32'd1);
    chk("bp_rel_valid", 32'(bus_if.rsp_valid_o), 32'd0);
    chk("bp_rel_cyc",   32'(bus_if.wbm_cyc_o), 32'd0);
    @(posedge clk); #1;
    bus_if.cmd_valid_i = 1'b0;
    chk("bp_acc_cyc", 32'(bus_if.wbm_cyc_o), 32'd1);
    chk("bp_acc_adr", bus_if.wbm_adr_o, 32'h4000_0000);
    bus_if.wbm_ack_i = 1'b1;
    bus_if.wbm_dat_i = 32'h0000_00AA;
    @(posedge clk); #1;
    bus_if.wbm_ack_i = 1'b0;
    chk("bp_acc_rsp", bus_if.rsp_dat_o, 32'h0000_00AA);
    consume();

    // Four more timeouts: counter saturates at 3
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b1, 4'hF, 32'h3000_0050, 32'h5555_0000, 0, 32'h0, stb_n, lat, rdat, rerr);
      consume();
    end
    chk("sat_err_cnt", 32'(err_cnt), 32'd3);

    // Reset asserted mid-BUS
    bus_if.cmd_valid_i = 1'b1;
    bus_if.cmd_we_i    = 1'b1;
    bus_if.cmd_adr_i   = 32'h3000_0060;
    @(posedge clk); #1;
    bus_if.cmd_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("mid_cyc_before", 32'(bus_if.wbm_cyc_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cyc",       32'(bus_if.wbm_cyc_o), 32'd0);
    chk("mid_rst_stb",       32'(bus_if.wbm_stb_o), 32'd0);
    chk("mid_rst_cmd_ready", 32'(bus_if.cmd_ready_o), 32'd1);
    chk("mid_rst_rsp_valid", 32'(bus_if.rsp_valid_o), 32'd0);
    chk("mid_rst_err_cnt",   32'(err_cnt), 32'd0);
    chk("mid_rst_adr",       bus_if.wbm_adr_o, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_rsp_valid", 32'(bus_if.rsp_valid_o), 32'd0);
    do_cmd(1'b0, 4'hF, 32'h3000_0070, 32'h0, 2, 32'h7777_8888, stb_n, lat, rdat, rerr);
    chk("post_rst_stb_n", 32'(stb_n), 32'd2);
    chk("post_rst_dat",   rdat, 32'h7777_8888);
    chk("post_rst_err",   32'(rerr), 32'd0);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
